algo_rgb888_2yuv422: RTL and testbench
======================================

// Module: algo_rgb888_2yuv422
// PURPOSE
//  Packs an RGB888 pixel stream into the 16-bit YUV422 format used at the CMOS input of the video pipeline.
//  Performs BT.601 full-range colour-space conversion and 2:1 horizontal chroma decimation.
//  Frame/line syncs travel alongside the data.
//  Sits at the output/loopback side of the camera path; its output feeds algo_yuv422_2yuv444-style consumers unchanged.
// PARAMETERS
//  CHROMA_AVG  1  1: pair chroma = rounded mean of both pixels; 0: pair chroma = even pixel's value only
//  CB_FIRST    1  1: even slot carries Cb, odd slot Cr; 0: swapped
// PORTS
//  clk         in   1   pixel clock; single clock domain
//  rst_n       in   1   asynchronous, active-low reset
//  i_vs        in   1   frame sync, passed through with data latency
//  i_hs        in   1   line sync, passed through with data latency
//  i_data_en   in   1   pixel valid; contiguous run per line (input contract)
//  i_r_8b      in   8   red
//  i_g_8b      in   8   green
//  i_b_8b      in   8   blue
//  o_q_16b     out  16  [15:8]=Y, [7:0]=chroma (Cb or Cr per slot)
//  o_vs        out  1   i_vs delayed 5 clk
//  o_hs        out  1   i_hs delayed 5 clk
//  o_data_en   out  1   i_data_en delayed 5 clk
// BEHAVIOUR
//  - Reset: all outputs, pipeline registers and pair phase = 0; async assert, sync release.
//  - Fixed latency 5 clk from input to output for data and all three syncs; no stalls, no backpressure.
//  - CSC (stages 1-3): products registered (S1), signed sums (S2), round/shift/offset/clamp (S3):
//      Y  = (77R + 150G + 29B + 128) >>> 8
//      Cb = ((-43R - 85G + 128B + 128) >>> 8) + 128
//      Cr = ((128R - 107G - 21B + 128) >>> 8) + 128
//    Sums are 18-bit signed with arithmetic shift. Each result is clamped to [0,255].
//  - Pair phase: toggles on each valid pixel. Forced to even on the rising edge of i_data_en and while i_vs=1.
//  - Pairing (stages 4-5):
//    - Even pixel E is emitted with avg Cb = (CbE+CbO+1)>>1.
//    - Next cycle, O is emitted with the stored avg Cr = (CrE+CrO+1)>>1.
//    - CHROMA_AVG=0: CbE and CrE are used directly.
//  - Odd-length run: the trailing unpaired pixel is emitted in an even slot using its own Cb (no averaging).
//  - o_q_16b = 0 whenever o_data_en=0.
//  - De-asserted i_data_en mid-pair is treated as end of run (as above); the next run restarts at even.
//  - Reset mid-line: pipeline flushed. Output resumes only on the next i_data_en rising edge, 5 clk later.
// STRUCTURE
//  - Shared package algo_pkg:
//    - BT.601 coefficient localparams: K_YR/K_YG/K_YB, K_CBR/K_CBG/K_CBB, K_CRR/K_CRG/K_CRB.
//    - ALGO_CSC_LAT=3 and the 8-bit clamp function.
//  - Sub-module algo_rgb2ycbcr_csc: 3-stage CSC pipeline plus matching 3-stage sync delay.
//  - Top level adds the pair phase, chroma averaging/slot mux and the final 2-stage sync delay.
// TESTING
//  1. Reset asserted mid-stream -> all outputs 0 immediately.
//     After release, first output appears 5 clk after the next de rise.
//  2. 4 white px (255,255,255) -> o_q_16b = 16'hFF80 x4. Black (0,0,0) -> 16'h0080 x4.
//  3. Red,red (255,0,0) -> 16'h4D55, 16'h4DFF.
//     Red,blue (0,0,255) -> 16'h4DAA, 16'h1DB5 (Y_blue=29, Cb avg 170, Cr avg 181).
//  4. Odd run of 3 px red,red,blue -> 16'h4D55, 16'h4DFF, 16'h1DFF (trailing blue keeps own Cb=255).
//     Next line starts even.
//  5. CHROMA_AVG=0 with red,blue -> 16'h4D55, 16'h1DFF.
//     CB_FIRST=0 with red,red -> 16'h4DFF, 16'h4D55.
//  6. Random frames with 640-px lines and hs/vs gaps -> o_vs/o_hs/o_data_en equal the inputs delayed exactly 5 clk.
//     o_q_16b matches the C reference model bit-exactly.

Source files
------------

// File: rtl/algo_pkg.sv
// Shared definitions for the RGB888 -> YUV422 path: BT.601 full-range
// coefficients, pipeline depths and small arithmetic helpers.
package algo_pkg;

    // Depth of the colour-space conversion pipeline (products, sums, clamp).
    localparam int ALGO_CSC_LAT = 3;

    // BT.601 full-range coefficients, scaled by 256.
    localparam logic signed [9:0] K_YR  =  10'sd77;
    localparam logic signed [9:0] K_YG  =  10'sd150;
    localparam logic signed [9:0] K_YB  =  10'sd29;
    localparam logic signed [9:0] K_CBR = -10'sd43;
    localparam logic signed [9:0] K_CBG = -10'sd85;
    localparam logic signed [9:0] K_CBB =  10'sd128;
    localparam logic signed [9:0] K_CRR =  10'sd128;
    localparam logic signed [9:0] K_CRG = -10'sd107;
    localparam logic signed [9:0] K_CRB = -10'sd21;

    // Sync bundle carried alongside pixel data.
    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
    } algo_sync_t;

    // Unsigned 8-bit pixel times signed coefficient, as an 18-bit signed product.
    function automatic logic signed [17:0] algo_cmul(input logic [7:0] px,
                                                     input logic signed [9:0] k);
        logic signed [17:0] a;
        logic signed [17:0] b;
        a = 18'(signed'({1'b0, px}));
        b = 18'(k);
        return a * b;
    endfunction

    // Saturate a signed intermediate to the 8-bit range [0,255].
    function automatic logic [7:0] algo_clamp8(input logic signed [17:0] v);
        if (v < 18'sd0) begin
            return 8'd0;
        end
        if (v > 18'sd255) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

    // Rounded mean of two 8-bit values: (a + b + 1) >> 1.
    function automatic logic [7:0] algo_mean8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction

endpackage

// File: rtl/algo_rgb2ycbcr_csc.sv
// Three-stage BT.601 RGB -> YCbCr converter with a matching sync delay line.
// Stage 1 registers the nine products, stage 2 the rounded signed sums,
// stage 3 the shifted, offset and clamped 8-bit results.
module algo_rgb2ycbcr_csc
    import algo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_vs,
    input  logic       i_hs,
    input  logic       i_data_en,
    input  logic [7:0] i_r_8b,
    input  logic [7:0] i_g_8b,
    input  logic [7:0] i_b_8b,
    output logic [7:0] o_y_8b,
    output logic [7:0] o_cb_8b,
    output logic [7:0] o_cr_8b,
    output logic       o_vs,
    output logic       o_hs,
    output logic       o_data_en
);

    logic signed [17:0] p_y_q  [3];
    logic signed [17:0] p_cb_q [3];
    logic signed [17:0] p_cr_q [3];
    logic signed [17:0] s_y_q;
    logic signed [17:0] s_cb_q;
    logic signed [17:0] s_cr_q;
    algo_sync_t         sync_q [ALGO_CSC_LAT];

    // Stage 1: register the per-channel products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                p_y_q[i]  <= '0;
                p_cb_q[i] <= '0;
                p_cr_q[i] <= '0;
            end
        end else begin
            p_y_q[0]  <= algo_cmul(i_r_8b, K_YR);
            p_y_q[1]  <= algo_cmul(i_g_8b, K_YG);
            p_y_q[2]  <= algo_cmul(i_b_8b, K_YB);
            p_cb_q[0] <= algo_cmul(i_r_8b, K_CBR);
            p_cb_q[1] <= algo_cmul(i_g_8b, K_CBG);
            p_cb_q[2] <= algo_cmul(i_b_8b, K_CBB);
            p_cr_q[0] <= algo_cmul(i_r_8b, K_CRR);
            p_cr_q[1] <= algo_cmul(i_g_8b, K_CRG);
            p_cr_q[2] <= algo_cmul(i_b_8b, K_CRB);
        end
    end

    // Stage 2: signed sums including the +128 rounding term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_y_q  <= '0;
            s_cb_q <= '0;
            s_cr_q <= '0;
        end else begin
            s_y_q  <= p_y_q[0]  + p_y_q[1]  + p_y_q[2]  + 18'sd128;
            s_cb_q <= p_cb_q[0] + p_cb_q[1] + p_cb_q[2] + 18'sd128;
            s_cr_q <= p_cr_q[0] + p_cr_q[1] + p_cr_q[2] + 18'sd128;
        end
    end

    // Stage 3: arithmetic shift, chroma offset and clamp to 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_y_8b  <= '0;
            o_cb_8b <= '0;
            o_cr_8b <= '0;
        end else begin
            o_y_8b  <= algo_clamp8(s_y_q >>> 8);
            o_cb_8b <= algo_clamp8((s_cb_q >>> 8) + 18'sd128);
            o_cr_8b <= algo_clamp8((s_cr_q >>> 8) + 18'sd128);
        end
    end

    // Sync delay line, same depth as the data path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ALGO_CSC_LAT; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {i_vs, i_hs, i_data_en};
            for (int i = 1; i < ALGO_CSC_LAT; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign o_vs      = sync_q[ALGO_CSC_LAT-1].vs;
    assign o_hs      = sync_q[ALGO_CSC_LAT-1].hs;
    assign o_data_en = sync_q[ALGO_CSC_LAT-1].de;

endmodule

// File: rtl/algo_rgb888_2yuv422.sv
// RGB888 -> 16-bit YUV422 packer. Converts each pixel to YCbCr, then pairs
// even/odd pixels so the even slot carries one chroma component and the odd
// slot the other, optionally averaged over the pair. Fixed 5-clock latency.
//
// Handshake: no backpressure. i_data_en qualifies the pixel on the same clock;
// o_data_en qualifies o_q_16b exactly 5 clocks later, and o_q_16b is zero
// whenever o_data_en is low.
module algo_rgb888_2yuv422
    import algo_pkg::*;
#(
    parameter bit CHROMA_AVG = 1'b1,
    parameter bit CB_FIRST   = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_vs,
    input  logic        i_hs,
    input  logic        i_data_en,
    input  logic [7:0]  i_r_8b,
    input  logic [7:0]  i_g_8b,
    input  logic [7:0]  i_b_8b,
    output logic [15:0] o_q_16b,
    output logic        o_vs,
    output logic        o_hs,
    output logic        o_data_en
);

    // Input gate: after reset a run already in progress is ignored until
    // i_data_en has been seen low, so output restarts on a fresh run.
    logic blocked_q;
    logic de_gated;

    // Stage-3 (CSC output) signals.
    logic [7:0] y3, cb3, cr3;
    logic       vs3, hs3, de3;
    logic [7:0] ce3, co3;
    logic       odd3;

    // Stage-4 registers and pairing state.
    logic [7:0] y4_q, ce4_q, co4_q;
    logic       de4_q, vs4_q, hs4_q, odd4_q;
    logic       phase_q;
    logic [7:0] hold_q;

    logic       paired;
    logic [7:0] c_even, c_odd;
    logic [15:0] q_d;

    // Track whether a run in progress at reset release is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocked_q <= 1'b1;
        end else if (!i_data_en) begin
            blocked_q <= 1'b0;
        end
    end

    assign de_gated = i_data_en & ~blocked_q;

    algo_rgb2ycbcr_csc u_csc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vs      (i_vs),
        .i_hs      (i_hs),
        .i_data_en (de_gated),
        .i_r_8b    (i_r_8b),
        .i_g_8b    (i_g_8b),
        .i_b_8b    (i_b_8b),
        .o_y_8b    (y3),
        .o_cb_8b   (cb3),
        .o_cr_8b   (cr3),
        .o_vs      (vs3),
        .o_hs      (hs3),
        .o_data_en (de3)
    );

    // Slot mapping, pixel phase and chroma selection for the output stage.
    // A pixel is odd only if it continues a run (previous cycle valid), vs is
    // low, and the phase toggle says so; a run start or vs forces even.
    always_comb begin
        ce3    = CB_FIRST ? cb3 : cr3;
        co3    = CB_FIRST ? cr3 : cb3;
        odd3   = de3 & de4_q & ~vs3 & phase_q;
        paired = de4_q & ~odd4_q & odd3;
        c_even = ce4_q;
        c_odd  = co4_q;
        if (CHROMA_AVG) begin
            c_odd = algo_mean8(co4_q, co3);
            if (paired) begin
                c_even = algo_mean8(ce4_q, ce3);
            end
        end
        q_d = '0;
        if (de4_q) begin
            q_d = odd4_q ? {y4_q, hold_q} : {y4_q, c_even};
        end
    end

    // Pair phase: toggles on each valid pixel reaching stage 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else if (de3) begin
            phase_q <= ~odd3;
        end
    end

    // Stage 4: hold one pixel so its partner can be seen before emission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y4_q   <= '0;
            ce4_q  <= '0;
            co4_q  <= '0;
            de4_q  <= 1'b0;
            vs4_q  <= 1'b0;
            hs4_q  <= 1'b0;
            odd4_q <= 1'b0;
        end else begin
            y4_q   <= y3;
            ce4_q  <= ce3;
            co4_q  <= co3;
            de4_q  <= de3;
            vs4_q  <= vs3;
            hs4_q  <= hs3;
            odd4_q <= odd3;
        end
    end

    // Odd-slot chroma captured when the even pixel of a pair is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (paired) begin
            hold_q <= c_odd;
        end
    end

    // Stage 5: output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q_16b   <= '0;
            o_vs      <= 1'b0;
            o_hs      <= 1'b0;
            o_data_en <= 1'b0;
        end else begin
            o_q_16b   <= q_d;
            o_vs      <= vs4_q;
            o_hs      <= hs4_q;
            o_data_en <= de4_q;
        end
    end

endmodule

// File: tb/tb_algo_rgb888_2yuv422.sv
// Bench for algo_rgb888_2yuv422: three parameter variants driven in parallel,
// a table of known vectors, random frames against a pixel-level model, and a
// reset-mid-line sequence.
module tb_algo_rgb888_2yuv422;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       i_vs = 1'b0, i_hs = 1'b0, i_data_en = 1'b0;
    logic [7:0] i_r_8b = '0, i_g_8b = '0, i_b_8b = '0;

    logic [15:0] q_a, q_n, q_s;
    logic        vs_a, hs_a, de_a, vs_n, hs_n, de_n, vs_s, hs_s, de_s;

    algo_rgb888_2yuv422 #(.CHROMA_AVG(1'b1), .CB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_data_en(i_data_en),
        .i_r_8b(i_r_8b), .i_g_8b(i_g_8b), .i_b_8b(i_b_8b),
        .o_q_16b(q_a), .o_vs(vs_a), .o_hs(hs_a), .o_data_en(de_a));

    algo_rgb888_2yuv422 #(.CHROMA_AVG(1'b0), .CB_FIRST(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_data_en(i_data_en),
        .i_r_8b(i_r_8b), .i_g_8b(i_g_8b), .i_b_8b(i_b_8b),
        .o_q_16b(q_n), .o_vs(vs_n), .o_hs(hs_n), .o_data_en(de_n));

    algo_rgb888_2yuv422 #(.CHROMA_AVG(1'b1), .CB_FIRST(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_hs(i_hs), .i_data_en(i_data_en),
        .i_r_8b(i_r_8b), .i_g_8b(i_g_8b), .i_b_8b(i_b_8b),
        .o_q_16b(q_s), .o_vs(vs_s), .o_hs(hs_s), .o_data_en(de_s));

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;

    // Per-input-cycle history as the design should see it (post reset gate).
    bit         h_de[$], h_vs[$], h_hs[$], h_odd[$];
    logic [7:0] h_r[$], h_g[$], h_b[$];
    logic [15:0] got_a[$], got_n[$], got_s[$];
    bit model_blocked = 1'b1;

    typedef struct {
        bit          de;
        bit          vs;
        logic [7:0]  r, g, b;
        logic [15:0] ea, en, es;
    } vec_t;
    vec_t tab[$];

    // ---------------- reference model ----------------
    function automatic int clamp255(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int y_of(int j);
        return clamp255((77*int'(h_r[j]) + 150*int'(h_g[j]) + 29*int'(h_b[j]) + 128) >>> 8);
    endfunction

    function automatic int cb_of(int j);
        return clamp255(((-43*int'(h_r[j]) - 85*int'(h_g[j]) + 128*int'(h_b[j]) + 128) >>> 8) + 128);
    endfunction

    function automatic int cr_of(int j);
        return clamp255(((128*int'(h_r[j]) - 107*int'(h_g[j]) - 21*int'(h_b[j]) + 128) >>> 8) + 128);
    endfunction

    // Chroma for the even slot / odd slot of pixel j.
    function automatic int ce_of(int j, bit cbf);
        return cbf ? cb_of(j) : cr_of(j);
    endfunction

    function automatic int co_of(int j, bit cbf);
        return cbf ? cr_of(j) : cb_of(j);
    endfunction

    function automatic logic [15:0] model_q(int j, bit avg, bit cbf);
        int c;
        if (j < 0) return 16'h0000;
        if (!h_de[j]) return 16'h0000;
        if (h_odd[j]) begin
            c = avg ? (co_of(j-1, cbf) + co_of(j, cbf) + 1) / 2 : co_of(j-1, cbf);
        end else if (avg && (j + 1 < h_de.size()) && h_odd[j+1]) begin
            c = (ce_of(j, cbf) + ce_of(j+1, cbf) + 1) / 2;
        end else begin
            c = ce_of(j, cbf);
        end
        return {8'(y_of(j)), 8'(c)};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input int idx, input logic [18:0] got,
                         input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got={vs,hs,de,q}=%h expected=%h", name, idx, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: check the output for the input applied 5 cycles earlier,
    // then drive the next input and record it in the history.
    task automatic step(input bit de_i, input bit vs_i, input bit hs_i,
                        input logic [7:0] r_i, input logic [7:0] g_i, input logic [7:0] b_i);
        int j, n;
        logic [2:0] es;
        bit eff, vsr, hsr, odd;
        @(negedge clk);
        j = h_de.size() - 5;
        es = '0;
        if (j >= 0) es = {h_vs[j], h_hs[j], h_de[j]};
        check("stream_avg",   j, {vs_a, hs_a, de_a, q_a}, {es, model_q(j, 1'b1, 1'b1)});
        check("stream_noavg", j, {vs_n, hs_n, de_n, q_n}, {es, model_q(j, 1'b0, 1'b1)});
        check("stream_crfst", j, {vs_s, hs_s, de_s, q_s}, {es, model_q(j, 1'b1, 1'b0)});
        if (j >= 0) begin
            got_a.push_back(q_a);
            got_n.push_back(q_n);
            got_s.push_back(q_s);
        end
        i_data_en = de_i; i_vs = vs_i; i_hs = hs_i;
        i_r_8b = r_i; i_g_8b = g_i; i_b_8b = b_i;
        eff = rst_n && de_i && !model_blocked;
        vsr = rst_n && vs_i;
        hsr = rst_n && hs_i;
        if (rst_n) model_blocked = model_blocked && de_i;
        n = h_de.size();
        odd = eff && (n > 0) && h_de[n-1] && !vsr && !h_odd[n-1];
        h_de.push_back(eff); h_vs.push_back(vsr); h_hs.push_back(hsr); h_odd.push_back(odd);
        h_r.push_back(r_i); h_g.push_back(g_i); h_b.push_back(b_i);
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic add(input bit de, input bit vs, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [15:0] ea, input logic [15:0] en,
                       input logic [15:0] es);
        vec_t v;
        v.de = de; v.vs = vs; v.r = r; v.g = g; v.b = b; v.ea = ea; v.en = en; v.es = es;
        tab.push_back(v);
    endtask

    task automatic clear_history();
        h_de.delete(); h_vs.delete(); h_hs.delete(); h_odd.delete();
        h_r.delete(); h_g.delete(); h_b.delete();
        got_a.delete(); got_n.delete(); got_s.delete();
        model_blocked = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int base, len;

        // Reset state.
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Known vectors: columns are expected o_q_16b for
        // (avg, Cb first) / (no avg, Cb first) / (avg, Cr first).
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 4; k++) add(1, 0, 255, 255, 255, 16'hFF80, 16'hFF80, 16'hFF80);
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 4; k++) add(1, 0,   0,   0,   0, 16'h0080, 16'h0080, 16'h0080);
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 0, 255,   0,   0, 16'h4D55, 16'h4D55, 16'h4DFF);
        add(1, 0, 255,   0,   0, 16'h4DFF, 16'h4DFF, 16'h4D55);
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 0, 255,   0,   0, 16'h4DAA, 16'h4D55, 16'h4DB5);
        add(1, 0,   0,   0, 255, 16'h1DB5, 16'h1DFF, 16'h1DAA);
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 0, 255,   0,   0, 16'h4D55, 16'h4D55, 16'h4DFF);
        add(1, 0, 255,   0,   0, 16'h4DFF, 16'h4DFF, 16'h4D55);
        add(1, 0,   0,   0, 255, 16'h1DFF, 16'h1DFF, 16'h1D6B);
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 0, 255,   0,   0, 16'h4D55, 16'h4D55, 16'h4DFF);
        add(1, 0, 255,   0,   0, 16'h4DFF, 16'h4DFF, 16'h4D55);
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);
        for (int k = 0; k < 3; k++) add(1, 1, 255, 0, 0, 16'h4D55, 16'h4D55, 16'h4DFF);
        add(0, 0,   0,   0,   0, 16'h0000, 16'h0000, 16'h0000);

        base = h_de.size();
        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].de, tab[i].vs, 1'b0, tab[i].r, tab[i].g, tab[i].b);
        end
        idle(8);
        for (int i = 0; i < tab.size(); i++) begin
            check("table_avg",   i, {3'b000, got_a[base+i]}, {3'b000, tab[i].ea});
            check("table_noavg", i, {3'b000, got_n[base+i]}, {3'b000, tab[i].en});
            check("table_crfst", i, {3'b000, got_s[base+i]}, {3'b000, tab[i].es});
        end

        // Random frames: vs pulse, hs pulses, 640-pixel lines plus one short
        // odd-length line per frame.
        for (int f = 0; f < 2; f++) begin
            repeat (3) step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
            idle($urandom_range(2, 5));
            for (int l = 0; l < 4; l++) begin
                len = (l == 3) ? (2 * $urandom_range(0, 4) + 1) : 640;
                repeat (2) step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
                idle($urandom_range(2, 6));
                for (int p = 0; p < len; p++) begin
                    step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
                end
                idle($urandom_range(1, 4));
            end
        end
        idle(8);

        // Reset asserted mid-line: outputs clear at once; after release the
        // remainder of the interrupted run is ignored until a fresh run starts.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_avg",   -1, {vs_a, hs_a, de_a, q_a}, 19'd0);
        check("reset_async_noavg", -1, {vs_n, hs_n, de_n, q_n}, 19'd0);
        check("reset_async_crfst", -1, {vs_s, hs_s, de_s, q_s}, 19'd0);
        clear_history();
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0);
        idle(3);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
